estufa_sequenciador: RTL and testbench

- Sequential actuation stage directly downstream of the greenhouse combinational controller.
- Consumes its heater request, cooler request and inconsistency flag, and drives the physical heater/cooler enables and the alarm.
- Adds request filtering, a minimum on-time, a dead-time between opposing actuators and a latched fault with operator acknowledge.
- Outputs feed LED[6], LED[7], SEG[7], and the state/counter go to the LCD debug bus.

---
 rtl/estufa_sequenciador.sv | 167 ++++++++++++++++
 tb/tb_estufa_sequenciador.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/estufa_sequenciador.sv
`default_nettype none
// ============================================================================
// Module      : estufa_sequenciador
// Description : Sequential actuation stage for the greenhouse controller.
//               It filters heater/cooler requests and enforces a minimum
//               on-time and a dead-time between the opposing actuators.
//               It also latches faults until the operator acknowledges them.
// Revision    : 1.0 - initial release
// ============================================================================
module estufa_sequenciador #(
    parameter int FILT      = 3,
    parameter int MIN_ON    = 8,
    parameter int DEAD_TIME = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk_2,
    input  logic             rst_n,
    input  logic             heat_req,
    input  logic             cool_req,
    input  logic             fault_in,
    input  logic             fault_ack,
    output logic             heater_on,
    output logic             cooler_on,
    output logic             alarm,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cnt_o
);

    // Stability counter only has to reach FILT-1.
    localparam int STAB_W = (FILT > 1) ? $clog2(FILT) : 1;

    localparam logic [STAB_W-1:0] C_STAB_MAX  = STAB_W'(FILT - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  C_MIN_ON_M1 = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0]  C_DEAD_M1   = CNT_W'(DEAD_TIME - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAT  = 3'd1,
        ST_COOL  = 3'd2,
        ST_DEAD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Bit 0 is heat and bit 1 is cool, for the raw, sampled and filtered vectors.
    logic [1:0]        w_raw;
    logic [1:0]        r_sample;
    logic [STAB_W-1:0] r_stab;
    logic [1:0]        r_filt;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;

    logic              w_err;
    logic              w_fh;
    logic              w_fc;
    logic              w_run_done;

    assign w_raw      = {cool_req, heat_req};
    assign w_fh       = r_filt[0];
    assign w_fc       = r_filt[1];
    // A simultaneous heat+cool request is contradictory and is treated like
    // a sensor fault, without filtering, so it takes effect on the next edge.
    assign w_err      = fault_in | (heat_req & cool_req);
    assign w_run_done = (r_cnt >= C_MIN_ON_M1);
    assign w_cnt_inc  = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Request filter: accept a new request vector only after it has been
    // stable long enough.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= 2'b00;
            r_stab   <= '0;
            r_filt   <= 2'b00;
        end else begin
            r_sample <= w_raw;
            if (w_raw != r_sample) begin
                r_stab <= '0;
            end else if (r_stab != C_STAB_MAX) begin
                r_stab <= r_stab + 1'b1;
            end else begin
                r_filt <= r_sample;
            end
        end
    end

    // State and run/dead counter registers.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic. An error overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_err) begin
            w_state_nxt = ST_FAULT;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_fh) begin
                        w_state_nxt = ST_HEAT;
                    end else if (w_fc) begin
                        w_state_nxt = ST_COOL;
                    end
                end
                ST_HEAT: begin
                    if ((!w_fh || w_fc) && w_run_done) begin
                        w_state_nxt = ST_DEAD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_COOL: begin
                    if ((!w_fc || w_fh) && w_run_done) begin
                        w_state_nxt = ST_DEAD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_DEAD: begin
                    if (r_cnt == C_DEAD_M1) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_FAULT: begin
                    // The acknowledge level matters only here, so an
                    // acknowledge held before the fault cannot pre-clear it.
                    w_cnt_nxt = '0;
                    if (fault_ack) begin
                        w_state_nxt = ST_DEAD;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Moore outputs: the enables decode from mutually exclusive states, so
    // the heater and cooler can never be on together.
    assign heater_on = (r_state == ST_HEAT);
    assign cooler_on = (r_state == ST_COOL);
    assign alarm     = (r_state == ST_FAULT);
    assign state_o   = r_state;
    assign cnt_o     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_estufa_sequenciador.sv
`default_nettype none
// ============================================================================
// Module      : tb_estufa_sequenciador
// Description : Self-checking bench for estufa_sequenciador. It runs directed
//               scenarios and then randomized stimulus, and compares every
//               cycle against a timer-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_estufa_sequenciador;

    localparam int FILT      = 3;
    localparam int MIN_ON    = 8;
    localparam int DEAD_TIME = 4;
    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk_2     = 1'b0;
    logic             rst_n     = 1'b0;
    logic             heat_req  = 1'b0;
    logic             cool_req  = 1'b0;
    logic             fault_in  = 1'b0;
    logic             fault_ack = 1'b0;
    logic             heater_on;
    logic             cooler_on;
    logic             alarm;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] cnt_o;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "reset";

    // Model state: the active actuator (0 none, 1 heater, 2 cooler), elapsed
    // run time, remaining dead time, the fault latch, and a sliding window of
    // raw request samples that drives the filtered requests.
    int         m_act;
    int         m_run;
    int         m_dead_left;
    bit         m_fault;
    bit         m_fh;
    bit         m_fc;
    logic [1:0] m_win[$];

    estufa_sequenciador #(
        .FILT      (FILT),
        .MIN_ON    (MIN_ON),
        .DEAD_TIME (DEAD_TIME),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_2     (clk_2),
        .rst_n     (rst_n),
        .heat_req  (heat_req),
        .cool_req  (cool_req),
        .fault_in  (fault_in),
        .fault_ack (fault_ack),
        .heater_on (heater_on),
        .cooler_on (cooler_on),
        .alarm     (alarm),
        .state_o   (state_o),
        .cnt_o     (cnt_o)
    );

    // Free-running clock.
    always #5 clk_2 = ~clk_2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act       = 0;
        m_run       = 0;
        m_dead_left = 0;
        m_fault     = 1'b0;
        m_fh        = 1'b0;
        m_fc        = 1'b0;
        // The cleared sample register counts as one all-zero sample.
        m_win.delete();
        m_win.push_back(2'b00);
    endtask

    function automatic int exp_state();
        if (m_fault)              return 4;
        else if (m_dead_left > 0) return 3;
        else                      return m_act;
    endfunction

    function automatic int exp_cnt();
        if (m_fault)              return 0;
        else if (m_dead_left > 0) return DEAD_TIME - m_dead_left;
        else if (m_act != 0)      return (m_run > CNT_MAX) ? CNT_MAX : m_run;
        else                      return 0;
    endfunction

    // One clock edge of the reference behaviour, using the inputs present at
    // that edge and the filtered requests from before it.
    task automatic model_step();
        logic [1:0] raw;
        bit         err;
        bit         own;
        bit         opp;
        bit         all_eq;
        raw = {cool_req, heat_req};
        err = fault_in | (heat_req & cool_req);
        if (err) begin
            m_fault     = 1'b1;
            m_act       = 0;
            m_run       = 0;
            m_dead_left = 0;
        end else if (m_fault) begin
            if (fault_ack) begin
                m_fault     = 1'b0;
                m_dead_left = DEAD_TIME;
            end
        end else if (m_dead_left > 0) begin
            m_dead_left--;
        end else if (m_act != 0) begin
            own = (m_act == 1) ? m_fh : m_fc;
            opp = (m_act == 1) ? m_fc : m_fh;
            if ((!own || opp) && (m_run >= MIN_ON - 1)) begin
                m_act       = 0;
                m_run       = 0;
                m_dead_left = DEAD_TIME;
            end else begin
                m_run++;
            end
        end else begin
            if (m_fh) begin
                m_act = 1;
                m_run = 0;
            end else if (m_fc) begin
                m_act = 2;
                m_run = 0;
            end
        end
        // A request is accepted once FILT+1 consecutive samples agree.
        m_win.push_back(raw);
        if (m_win.size() > FILT + 1) void'(m_win.pop_front());
        if (m_win.size() == FILT + 1) begin
            all_eq = 1'b1;
            foreach (m_win[i]) if (m_win[i] != raw) all_eq = 1'b0;
            if (all_eq) begin
                m_fh = raw[0];
                m_fc = raw[1];
            end
        end
    endtask

    task automatic check_all();
        int es;
        es = exp_state();
        check_eq({phase, ".state"},  state_o, es);
        check_eq({phase, ".cnt"},    cnt_o, exp_cnt());
        check_eq({phase, ".heater"}, heater_on, (es == 1) ? 1 : 0);
        check_eq({phase, ".cooler"}, cooler_on, (es == 2) ? 1 : 0);
        check_eq({phase, ".alarm"},  alarm, (es == 4) ? 1 : 0);
        check_eq({phase, ".excl"},   heater_on & cooler_on, 0);
    endtask

    task automatic tick();
        @(posedge clk_2);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        int  heat_cnt;
        int  dead_cnt;
        int  dead_len;
        int  prev;
        bit  saw_cool;
        int  cyc;
        int  kind;
        int  len;

        model_reset();
        // Reset is applied at the first edge, then checked.
        #7;
        check_all();

        // 1: heat request reaches the heater FILT+2 edges later.
        phase    = "t1";
        rst_n    = 1'b1;
        heat_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("t1.early_heater", heater_on, 0);
        end
        tick();
        check_eq("t1.heater_on", heater_on, 1);
        check_eq("t1.state_heat", state_o, 1);

        // 2: request drops early; the minimum on-time holds, then dead-time.
        phase    = "t2";
        heat_cnt = 0;
        dead_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) heat_req = 1'b0;
            tick();
            if (heater_on) heat_cnt++;
            if (state_o == 3'd3) dead_cnt++;
        end
        check_eq("t2.heat_extra_cycles", heat_cnt, MIN_ON - 1);
        check_eq("t2.dead_cycles", dead_cnt, DEAD_TIME);
        check_eq("t2.back_idle", state_o, 0);

        // 3: switch from heating to cooling; dead-time must separate them.
        phase    = "t3";
        heat_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_eq("t3.heating", heater_on, 1);
        heat_req = 1'b0;
        cool_req = 1'b1;
        saw_cool = 1'b0;
        dead_len = 0;
        prev     = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (state_o == 3'd3) dead_len = (prev == 3) ? dead_len + 1 : 1;
            if (state_o == 3'd2 && !saw_cool) begin
                saw_cool = 1'b1;
                check_eq("t3.dead_before_cool", dead_len, DEAD_TIME);
            end
            prev = int'(state_o);
        end
        check_eq("t3.cool_reached", saw_cool, 1);

        // 4: a one-cycle fault latches the alarm until it is acknowledged.
        phase    = "t4";
        fault_in = 1'b1;
        cool_req = 1'b0;
        tick();
        check_eq("t4.cooler_off", cooler_on, 0);
        check_eq("t4.alarm_set", alarm, 1);
        fault_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t4.alarm_held", alarm, 1);
        end
        fault_ack = 1'b1;
        tick();
        check_eq("t4.dead_after_ack", state_o, 3);
        fault_ack = 1'b0;
        for (int i = 0; i < DEAD_TIME - 1; i++) tick();
        check_eq("t4.still_dead", state_o, 3);
        tick();
        check_eq("t4.idle", state_o, 0);

        // 5: an acknowledge while the fault persists is ignored.
        phase    = "t5";
        fault_in = 1'b1;
        tick();
        fault_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t5.stays_fault", state_o, 4);
        end
        fault_in = 1'b0;
        tick();
        check_eq("t5.dead_on_clear", state_o, 3);
        fault_ack = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // 6: glitching request never starts the heater; reset drops it at once.
        phase = "t6";
        for (int i = 0; i < 24; i++) begin
            heat_req = ~heat_req;
            tick();
            check_eq("t6.glitch_idle", state_o, 0);
        end
        heat_req = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_eq("t6.heating", heater_on, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6.async_heater", heater_on, 0);
        check_eq("t6.async_state", state_o, 0);
        check_eq("t6.async_cnt", cnt_o, 0);
        model_reset();
        @(negedge clk_2);
        heat_req = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Randomized segments of requests, noise, faults and acknowledges.
        phase = "rand";
        cyc   = 0;
        while (cyc < 2500) begin
            kind = $urandom_range(0, 19);
            len  = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) begin
                case (kind)
                    0, 1, 2, 3, 4, 5, 6: begin heat_req = 1'b1; cool_req = 1'b0; end
                    7, 8, 9, 10, 11, 12, 13: begin heat_req = 1'b0; cool_req = 1'b1; end
                    14, 15, 16: begin heat_req = 1'b0; cool_req = 1'b0; end
                    17, 18: begin
                        heat_req = 1'($urandom_range(0, 1));
                        cool_req = heat_req ? 1'b0 : 1'($urandom_range(0, 1));
                    end
                    default: begin
                        heat_req = 1'($urandom_range(0, 1));
                        cool_req = 1'($urandom_range(0, 1));
                    end
                endcase
                fault_in  = ($urandom_range(0, 99) < 2);
                fault_ack = ($urandom_range(0, 99) < 25);
                tick();
                cyc++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
